square_oscillator: RTL and testbench

//  Square-wave oscillator voice with externally loadable state, so one core can
//  be time-multiplexed over many synth voices (state reloaded from a per-voice bank).

---
 rtl/square_oscillator.sv | 87 ++++++++
 tb/tb_square_oscillator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/square_oscillator.sv
// Square-wave oscillator voice with externally loadable (counter, sample) state.
// Define SQUARE_LOWPASS_EN to add a single-pole IIR low-pass stage on filt_out.
module square_oscillator #(
    parameter int WIDTH        = 32,
    parameter int AMP_SHIFT    = 20,
    parameter int FILTER_SHIFT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [WIDTH-1:0] set_sample,
    input  logic [WIDTH-1:0] set_counter,
    input  logic [WIDTH-1:0] wave_length,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] filt_out
);

    localparam logic [WIDTH-1:0] AMP_LEVEL  = WIDTH'(1) << AMP_SHIFT;
    localparam logic [WIDTH-1:0] IDLE_LEVEL = ~AMP_LEVEL + WIDTH'(1);

    logic [WIDTH-1:0] half_raw;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cur_sample;
    logic [WIDTH-1:0] cur_count;
    logic [WIDTH:0]   count_inc;
    logic             wrap;
    logic [WIDTH-1:0] next_counter;
    logic [WIDTH-1:0] next_out;

    assign half_raw = wave_length >> 1;
    assign half     = (half_raw == '0) ? WIDTH'(1) : half_raw;

    // One extra bit keeps a loaded all-ones counter from wrapping past the compare.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cur_sample   = out;
        cur_count    = counter;
        next_counter = '0;
        next_out     = '0;
        if (set) begin
            cur_sample = set_sample;
            cur_count  = set_counter;
        end
        count_inc = {1'b0, cur_count} + (WIDTH+1)'(1);
        wrap      = count_inc >= {1'b0, half};
        if (wrap) begin
            next_counter = '0;
            next_out     = -cur_sample;
        end else begin
            next_counter = count_inc[WIDTH-1:0];
            next_out     = cur_sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            counter <= '0;
            out     <= IDLE_LEVEL;
        end else begin
            counter <= next_counter;
            out     <= next_out;
        end
    end

`ifdef SQUARE_LOWPASS_EN
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] diff;

    // Filter input is the registered sample, so y trails out by one cycle.
    assign diff = $signed(out) - y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
        end else begin
            y <= y + (diff >>> FILTER_SHIFT);
        end
    end

    assign filt_out = y;
`else
    assign filt_out = out;
`endif

endmodule

// File: tb/tb_square_oscillator.sv
// Self-checking bench for square_oscillator: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_square_oscillator;

    logic        clk = 1'b0;
    logic        reset;
    logic        set;
    logic [31:0] set_sample;
    logic [31:0] set_counter;
    logic [31:0] wave_length;
    logic [31:0] counter;
    logic [31:0] out;
    logic [31:0] filt_out;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

`ifdef SQUARE_LOWPASS_EN
    localparam logic [31:0] RST_FILT = 32'h0000_0000;
`else
    localparam logic [31:0] RST_FILT = 32'hFFF0_0000;
`endif

    always #5 clk = ~clk;

    square_oscillator dut (
        .clk         (clk),
        .reset       (reset),
        .set         (set),
        .set_sample  (set_sample),
        .set_counter (set_counter),
        .wave_length (wave_length),
        .counter     (counter),
        .out         (out),
        .filt_out    (filt_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: voice state as plain integers, filter as a signed running average.
    logic [31:0] m_cnt;
    int          m_out;
    int          m_y;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0;
            m_out = -(1 << 20);
            m_y   = 0;
        end else begin
            longint unsigned h;
            longint unsigned c;
            int              s;
            m_y = m_y + ((m_out - m_y) >>> 4);
            h = longint'(wave_length / 2);
            if (h == 0) h = 1;
            s = set ? int'(set_sample) : m_out;
            c = set ? longint'(set_counter) : longint'(m_cnt);
            if (c + 1 >= h) begin
                m_cnt = 0;
                m_out = -s;
            end else begin
                m_cnt = 32'(c + 1);
                m_out = s;
            end
        end
    end

    function automatic logic [31:0] model_filt();
`ifdef SQUARE_LOWPASS_EN
        return m_y;
`else
        return m_out;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_counter", counter, m_cnt);
            check("model_out", out, m_out);
            check("model_filt", filt_out, model_filt());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        set         = 1'b0;
        set_sample  = '0;
        set_counter = '0;
        wave_length = 32'd8;
        reset       = 1'b0;

        // Asynchronous reset: outputs settle without a clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_out", out, 32'hFFF0_0000);
        check("rst_counter", counter, 32'd0);
        check("rst_filt", filt_out, RST_FILT);
        tick();
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Free run, wave_length=8: counter 1,2,3,0 with a flip every 4 edges.
        tick(); check("run_c1", counter, 32'd1);
        tick(); check("run_c2", counter, 32'd2);
        tick(); check("run_c3", counter, 32'd3); check("run_out3", out, 32'hFFF0_0000);
        tick(); check("run_c0", counter, 32'd0); check("run_flip4", out, 32'h0010_0000);
        tick(); tick(); tick();
        check("run_out7", out, 32'h0010_0000);
        tick(); check("run_flip8", out, 32'hFFF0_0000); check("run_c8", counter, 32'd0);

        // Load state.
        set = 1'b1; set_sample = 32'd1000; set_counter = 32'd2;
        tick(); check("load_c", counter, 32'd3); check("load_out", out, 32'd1000);
        set_counter = 32'd3;
        tick(); check("load_wrap_c", counter, 32'd0); check("load_wrap_out", out, 32'hFFFF_FC18);
        set = 1'b0;

        // Shortened period with counter already past the new half.
        tick(); tick(); tick();
        check("short_pre_c", counter, 32'd3);
        wave_length = 32'd2;
        tick(); check("short_c", counter, 32'd0); check("short_out", out, 32'd1000);
        tick(); check("short_out2", out, 32'hFFFF_FC18);

        // wave_length=0 toggles every edge.
        wave_length = 32'd0;
        tick(); check("wl0_out_a", out, 32'd1000); check("wl0_c_a", counter, 32'd0);
        tick(); check("wl0_out_b", out, 32'hFFFF_FC18); check("wl0_c_b", counter, 32'd0);

        // Mid-operation reset, then hold out at the idle level to pin the filter.
        reset = 1'b1;
        #1;
        check("rst2_out", out, 32'hFFF0_0000);
        check("rst2_filt", filt_out, RST_FILT);
        set = 1'b1; set_sample = 32'hFFF0_0000; set_counter = 32'd0; wave_length = 32'h0000_1000;
        tick();
        reset = 1'b0;
        tick();
        check("hold_out1", out, 32'hFFF0_0000);
`ifdef SQUARE_LOWPASS_EN
        check("filt_y1", filt_out, 32'hFFFF_0000);
        tick(); check("filt_y2", filt_out, 32'hFFFE_1000);
`else
        check("filt_pass1", filt_out, 32'hFFF0_0000);
        tick(); check("filt_pass2", filt_out, 32'hFFF0_0000);
`endif
        set = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            set   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       set_sample = 32'h8000_0000;
                1:       set_sample = 32'd0;
                default: set_sample = $urandom;
            endcase
            set_counter = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 50);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 5))
                    0:       wave_length = 32'd0;
                    1:       wave_length = 32'd1;
                    2:       wave_length = 32'd2;
                    3:       wave_length = 32'd3;
                    4:       wave_length = $urandom;
                    default: wave_length = $urandom_range(4, 40);
                endcase
            end
        end
        tick();
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
